// File: rtl/r5p_rvmodel_pkg.sv
// r5p_rvmodel_pkg: register offsets and FSM states of the RVMODEL compliance controller
package r5p_rvmodel_pkg;
  localparam logic [4:0] ADR_BEG  = 5'h00;
  localparam logic [4:0] ADR_END  = 5'h08;
  localparam logic [4:0] ADR_HALT = 5'h10;
  localparam logic [4:0] ADR_STAT = 5'h14;
  localparam logic [4:0] ADR_CNT  = 5'h18;
  typedef enum logic [2:0] {RUN, SETUP, REQ, RSP, OUT, DONE} state_t;
endpackage

// File: rtl/r5p_rvmodel_ctl.sv
// r5p_rvmodel_ctl: captures RVMODEL begin/end/halt, times out, then streams the signature from memory
module r5p_rvmodel_ctl
  import r5p_rvmodel_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 22,
  parameter int unsigned TMO = 10000
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          sub_vld,
  input  logic          sub_wen,
  input  logic [4:0]    sub_adr,
  input  logic [DW-1:0] sub_wdt,
  output logic          sub_rdy,
  output logic [DW-1:0] sub_rdt,
  output logic          man_vld,
  output logic [AW-1:0] man_adr,
  input  logic          man_rdy,
  input  logic [DW-1:0] man_rdt,
  output logic          sig_vld,
  output logic [DW-1:0] sig_dat,
  output logic          sig_lst,
  input  logic          sig_rdy,
  output logic          done,
  output logic          tmo
);
  localparam int unsigned BW = DW/8;
  localparam logic [DW-1:0] TOP = DW'({1'b1, {AW{1'b0}}});
  state_t state, state_nxt;
  logic [DW-1:0] beg_r, end_r, sig_q, beg_al, end_al, rdata;
  logic [31:0] cnt;
  logic [AW:0] ptr, lim, lim_set, ptr_nxt;
  logic lst_q, tmo_r, wr, rd, halt_wr, tmo_hit;
  assign wr      = sub_vld & sub_wen;
  assign rd      = sub_vld & ~sub_wen;
  assign halt_wr = wr && sub_adr == ADR_HALT && sub_wdt[0] && state == RUN;
  assign tmo_hit = TMO != 0 && state == RUN && cnt == 32'(TMO - 1);
  assign beg_al  = beg_r & ~DW'(BW - 1);
  assign end_al  = end_r & ~DW'(BW - 1);
  // the limit is one bit wider than the address so a window ending at 2^AW stays representable
  assign lim_set = end_al >= TOP ? {1'b1, {AW{1'b0}}} : end_al[AW:0];
  assign ptr_nxt = ptr + (AW+1)'(BW);
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = (halt_wr || tmo_hit) ? SETUP : RUN;
      SETUP:   state_nxt = beg_al >= DW'(lim_set) ? DONE : REQ;
      REQ:     state_nxt = man_rdy ? RSP : REQ;
      RSP:     state_nxt = OUT;
      OUT:     state_nxt = sig_rdy ? (lst_q ? DONE : REQ) : OUT;
      default: state_nxt = DONE;
    endcase
  end
  always_comb begin
    rdata = sub_adr == ADR_BEG  ? beg_r :
            sub_adr == ADR_END  ? end_r :
            sub_adr == ADR_STAT ? DW'({done, tmo_r, state}) :
            sub_adr == ADR_CNT  ? DW'(cnt) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      beg_r   <= '0;
      end_r   <= '0;
      tmo_r   <= 1'b0;
      ptr     <= '0;
      lim     <= '0;
      sig_q   <= '0;
      lst_q   <= 1'b0;
      sub_rdt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && cnt != '1) cnt <= cnt + 1'b1;
      if (state == RUN && wr && sub_adr == ADR_BEG) beg_r <= sub_wdt;
      if (state == RUN && wr && sub_adr == ADR_END) end_r <= sub_wdt;
      if (tmo_hit && !halt_wr) tmo_r <= 1'b1;
      if (state == SETUP) begin
        ptr <= beg_al[AW:0];
        lim <= lim_set;
      end
      if (state == RSP) begin
        sig_q <= man_rdt;
        lst_q <= ptr_nxt >= lim;
        ptr   <= ptr_nxt;
      end
      if (rd) sub_rdt <= rdata;
    end
  end
  assign sub_rdy = 1'b1;
  assign man_vld = state == REQ;
  assign man_adr = man_vld ? ptr[AW-1:0] : '0;
  assign sig_vld = state == OUT;
  assign sig_dat = sig_vld ? sig_q : '0;
  assign sig_lst = sig_vld & lst_q;
  assign done    = state == DONE;
  assign tmo     = tmo_r;
endmodule
